// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first, with a
// start/done handshake. {carry_out, sum} = a + b + carry_in after NUM_BITS+1 cycles.
module serial_adder_ctrl #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out
);

  localparam int unsigned CntW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(NUM_BITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] a_sh_q, a_sh_d;
  logic [NUM_BITS-1:0] b_sh_q, b_sh_d;
  logic [NUM_BITS-1:0] sum_sh_q, sum_sh_d;
  logic [NUM_BITS-1:0] sum_q, sum_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                carry_out_q, carry_out_d;
  logic                fa_s, fa_c;

  // Single full-adder slice shared across all bit positions.
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_s, sum_sh_q[NUM_BITS-1:1]};
        carry_d  = fa_c;
        if (cnt_q == CntMax) begin
          sum_d       = {fa_s, sum_sh_q[NUM_BITS-1:1]};
          carry_out_d = fa_c;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule
